// File: rtl/bringup_pattern_driver_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bringup_pattern_driver_pkg                                               |
// | Mode codes and FSM state encodings shared by the bring-up pin driver.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package bringup_pattern_driver_pkg;

  localparam logic [2:0] MODE_RELEASE    = 3'd0;
  localparam logic [2:0] MODE_DRIVE_LOW  = 3'd1;
  localparam logic [2:0] MODE_DRIVE_HIGH = 3'd2;
  localparam logic [2:0] MODE_TOGGLE     = 3'd3;
  localparam logic [2:0] MODE_SCAN       = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_STATIC     = 3'd1,
    ST_TOGGLE     = 3'd2,
    ST_SCAN_DRIVE = 3'd3,
    ST_SCAN_GAP   = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/bringup_pattern_driver_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bringup_pattern_driver_if                                                |
// | Command handshake and pin-drive bundle between decoder and pin driver.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface bringup_pattern_driver_if #(
  parameter int NUM_PINS = 8
);
  localparam int PW = $clog2(NUM_PINS);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [2:0]          cmd_mode;
  logic [PW-1:0]       cmd_pin;
  logic [NUM_PINS-1:0] pins_o;
  logic [NUM_PINS-1:0] pins_oe;
  logic                busy;
  logic [PW-1:0]       scan_pin;
  logic                done;

  modport master (
    output cmd_valid, cmd_mode, cmd_pin,
    input  cmd_ready, pins_o, pins_oe, busy, scan_pin, done
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_pin,
    output cmd_ready, pins_o, pins_oe, busy, scan_pin, done
  );

endinterface
`default_nettype wire

// File: rtl/bringup_pattern_driver_tick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bringup_tick                                                             |
// | Reloadable down-counter producing one tick every PERIOD clocks.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bringup_tick #(
  parameter int PERIOD = 6000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic restart,
  output logic tick,
  output logic pre_tick
);

  localparam int CW = $clog2(PERIOD + 1);
  localparam logic [CW-1:0] C_RELOAD = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q;

  always_comb begin
    cnt_d = cnt_q - CW'(1);
    if (restart || (cnt_q == '0)) begin
      cnt_d = C_RELOAD;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_q | restart;
    end
  end

  // pre_tick lets the owner land a registered change exactly on the tick cycle.
  assign tick     = armed_q && (cnt_q == '0);
  assign pre_tick = armed_q && (cnt_q == CW'(1));

endmodule
`default_nettype wire

// File: rtl/bringup_pattern_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bringup_pattern_driver                                                   |
// | Drives one pin low/high/toggling, or scans all pins in turn with gaps.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bringup_pattern_driver
  import bringup_pattern_driver_pkg::*;
#(
  parameter int NUM_PINS          = 8,
  parameter int CLOCKS_PER_TOGGLE = 6000,
  parameter int DWELL_TOGGLES     = 256,
  parameter int GAP_TICKS         = 256
) (
  input  logic                      clock,
  input  logic                      reset_n,
  bringup_pattern_driver_if.slave   bus
);

  localparam int PW = $clog2(NUM_PINS);
  localparam int TW = $clog2(DWELL_TOGGLES + 1);
  localparam int GW = $clog2(GAP_TICKS + 1);

  localparam logic [TW-1:0] C_LAST_TRANS = TW'(DWELL_TOGGLES - 1);
  localparam logic [GW-1:0] C_LAST_GAP   = GW'(GAP_TICKS - 1);
  localparam logic [PW-1:0] C_LAST_PIN   = PW'(NUM_PINS - 1);

  state_e              state_q;
  logic [NUM_PINS-1:0] pins_o_q;
  logic [NUM_PINS-1:0] pins_oe_q;
  logic [PW-1:0]       scan_pin_q;
  logic [TW-1:0]       trans_q;
  logic [GW-1:0]       gap_q;
  logic                done_q;

  logic                w_scanning;
  logic                w_accept;
  logic                w_tick;
  logic                w_pre_tick;
  logic                w_pin_ok;
  logic [NUM_PINS-1:0] w_cmd_mask;
  logic [PW-1:0]       w_next_pin;
  logic [NUM_PINS-1:0] w_next_mask;
  logic                w_last_pin;

  assign w_scanning  = (state_q == ST_SCAN_DRIVE) || (state_q == ST_SCAN_GAP);
  assign w_accept    = bus.cmd_valid && !w_scanning;
  assign w_pin_ok    = {1'b0, bus.cmd_pin} < (PW + 1)'(NUM_PINS);
  assign w_cmd_mask  = NUM_PINS'(1) << bus.cmd_pin;
  assign w_next_pin  = scan_pin_q + PW'(1);
  assign w_next_mask = NUM_PINS'(1) << w_next_pin;
  assign w_last_pin  = (scan_pin_q == C_LAST_PIN);

  bringup_tick #(
    .PERIOD (CLOCKS_PER_TOGGLE)
  ) u_tick (
    .clock    (clock),
    .reset_n  (reset_n),
    .restart  (w_accept),
    .tick     (w_tick),
    .pre_tick (w_pre_tick)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pins_o_q   <= '0;
      pins_oe_q  <= '0;
      scan_pin_q <= '0;
      trans_q    <= '0;
      gap_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (w_accept) begin
        pins_o_q   <= '0;
        pins_oe_q  <= '0;
        scan_pin_q <= '0;
        trans_q    <= '0;
        gap_q      <= '0;
        state_q    <= ST_IDLE;
        case (bus.cmd_mode)
          MODE_DRIVE_LOW, MODE_DRIVE_HIGH: begin
            if (w_pin_ok) begin
              state_q   <= ST_STATIC;
              pins_oe_q <= w_cmd_mask;
              pins_o_q  <= (bus.cmd_mode == MODE_DRIVE_HIGH) ? w_cmd_mask : '0;
            end
          end
          MODE_TOGGLE: begin
            if (w_pin_ok) begin
              state_q   <= ST_TOGGLE;
              pins_oe_q <= w_cmd_mask;
            end
          end
          MODE_SCAN: begin
            state_q   <= ST_SCAN_DRIVE;
            pins_oe_q <= NUM_PINS'(1);
          end
          default: state_q <= ST_IDLE;
        endcase
      end else begin
        case (state_q)
          ST_TOGGLE: begin
            if (w_tick) pins_o_q <= pins_o_q ^ pins_oe_q;
          end
          ST_SCAN_DRIVE: begin
            if (w_tick) begin
              if (trans_q == C_LAST_TRANS) begin
                pins_o_q  <= '0;
                pins_oe_q <= '0;
                gap_q     <= '0;
                state_q   <= ST_SCAN_GAP;
              end else begin
                pins_o_q <= pins_o_q ^ pins_oe_q;
                trans_q  <= trans_q + TW'(1);
              end
            end
          end
          ST_SCAN_GAP: begin
            // Finish one cycle early so done lands on the final gap tick.
            if (w_last_pin && (gap_q == C_LAST_GAP) && w_pre_tick) begin
              state_q    <= ST_IDLE;
              scan_pin_q <= '0;
              done_q     <= 1'b1;
            end else if (w_tick) begin
              if ((gap_q == C_LAST_GAP) && !w_last_pin) begin
                scan_pin_q <= w_next_pin;
                pins_oe_q  <= w_next_mask;
                pins_o_q   <= '0;
                trans_q    <= '0;
                state_q    <= ST_SCAN_DRIVE;
              end else begin
                gap_q <= gap_q + GW'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.cmd_ready = !w_scanning;
  assign bus.busy      = w_scanning;
  assign bus.pins_o    = pins_o_q;
  assign bus.pins_oe   = pins_oe_q;
  assign bus.scan_pin  = scan_pin_q;
  assign bus.done      = done_q;

endmodule
`default_nettype wire
